// File: rtl/nbank_mem_cof_burst_ctrl_if.sv
// Bus bundle between the MFCC datapath/host side and the coefficient bank controller.
// The master drives addresses, enables and SRAM read data; the controller is the slave.
interface nbank_mem_cof_burst_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_BITS  = 2,
    parameter int unsigned LEN_WIDTH  = 14
);
    localparam int unsigned NUM_BANKS = 2 ** BANK_BITS;

    logic                            ext_sel;
    logic [ADDR_WIDTH-1:0]           ext_addr;
    logic                            ext_ren;
    logic [ADDR_WIDTH-1:0]           sys_addr;
    logic                            sys_cen_sel;
    logic                            sys_wen_in;
    logic                            sys_wen_out;
    logic                            burst_start;
    logic [ADDR_WIDTH-1:0]           burst_base;
    logic [LEN_WIDTH-1:0]            burst_len;
    logic                            burst_busy;
    logic                            burst_done;
    logic [NUM_BANKS*DATA_WIDTH-1:0] q;
    logic [NUM_BANKS-1:0]            cen;
    logic [ADDR_WIDTH-BANK_BITS-1:0] bank_addr;
    logic [DATA_WIDTH-1:0]           rdata;
    logic                            rdata_valid;

    modport master (
        output ext_sel, ext_addr, ext_ren, sys_addr, sys_cen_sel, sys_wen_in,
               burst_start, burst_base, burst_len, q,
        input  sys_wen_out, burst_busy, burst_done, cen, bank_addr, rdata, rdata_valid
    );

    modport slave (
        input  ext_sel, ext_addr, ext_ren, sys_addr, sys_cen_sel, sys_wen_in,
               burst_start, burst_base, burst_len, q,
        output sys_wen_out, burst_busy, burst_done, cen, bank_addr, rdata, rdata_valid
    );
endinterface

// File: rtl/nbank_mem_cof_burst_ctrl.sv
// Coefficient SRAM bank controller: address select, bank decode, latency-aligned read
// return and an autonomous burst reader for pre-loading contiguous coefficient ranges.
module nbank_mem_cof_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_BITS  = 2,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned LEN_WIDTH  = 14
) (
    input logic                  clk,
    input logic                  rst_n,
    nbank_mem_cof_burst_ctrl_if.slave bus
);
    localparam int unsigned NUM_BANKS = 2 ** BANK_BITS;
    localparam int unsigned BA_WIDTH  = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned DCNT_W    = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DCNT_W-1:0]     drain_q, drain_d;
    logic                  done_c;

    logic                  run;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [BANK_BITS-1:0]  bank;
    logic [NUM_BANKS-1:0]  cen_c;
    logic                  req;

    logic [BANK_BITS-1:0]  bank_pipe_q [RD_LAT];
    logic [RD_LAT-1:0]     req_pipe_q;
    logic [DATA_WIDTH-1:0] q_words [NUM_BANKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_cnt_q <= '0;
            rem_q      <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        done_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.burst_start) begin
                    if (bus.burst_len != '0) begin
                        addr_cnt_d = bus.burst_base;
                        rem_d      = bus.burst_len;
                        state_d    = StRun;
                    end else begin
                        // Zero-length burst: no access, done on the following cycle.
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end
            end
            StRun: begin
                addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                rem_d      = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) begin
                    drain_d = DCNT_W'(RD_LAT);
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Done fires in the cycle the count would reach zero, i.e. with the last valid.
                if (drain_q <= DCNT_W'(1)) begin
                    done_c  = 1'b1;
                    drain_d = '0;
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q - DCNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign run      = (state_q == StRun);
    assign addr_sel = run ? addr_cnt_q : (bus.ext_sel ? bus.ext_addr : bus.sys_addr);
    assign bank     = addr_sel[ADDR_WIDTH-1 -: BANK_BITS];
    assign req      = run || (bus.ext_sel && bus.ext_ren && bus.sys_cen_sel);

    always_comb begin
        cen_c = '0;
        if (run || bus.sys_cen_sel) begin
            cen_c[bank] = 1'b1;
        end
    end

    assign bus.cen         = cen_c;
    assign bus.bank_addr   = addr_sel[BA_WIDTH-1:0];
    assign bus.sys_wen_out = run ? 1'b1 : bus.sys_wen_in;
    assign bus.burst_busy  = (state_q != StIdle);
    assign bus.burst_done  = done_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                bank_pipe_q[i] <= '0;
            end
            req_pipe_q <= '0;
        end else begin
            bank_pipe_q[0] <= bank;
            req_pipe_q[0]  <= req;
            for (int i = 1; i < RD_LAT; i++) begin
                bank_pipe_q[i] <= bank_pipe_q[i-1];
                req_pipe_q[i]  <= req_pipe_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_q_words
        assign q_words[k] = bus.q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bus.rdata       = q_words[bank_pipe_q[RD_LAT-1]];
    assign bus.rdata_valid = req_pipe_q[RD_LAT-1];
endmodule

// File: tb/tb_nbank_mem_cof_burst_ctrl.sv
// Scoreboard bench: two controllers (read latency 1 and 3) share stimulus; expected reads
// and done pulses are queued at issue time and retired by per-controller monitors.
module tb_nbank_mem_cof_burst_ctrl;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned BB = 2;
    localparam int unsigned LW = 14;
    localparam int unsigned NB = 4;

    typedef struct {
        int unsigned cyc;
        int unsigned bank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    exp_t        rq1[$];
    exp_t        rq3[$];
    int unsigned dq1[$];
    int unsigned dq3[$];

    logic [NB*DW-1:0] q_vec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank k word changes every cycle, so a wrong latency shows up as wrong data.
    function automatic logic [31:0] qword(int unsigned c, int unsigned k);
        logic [7:0] kb;
        kb = 8'(k);
        return {8'hA0 | kb, 8'h5A, c[15:0]};
    endfunction

    always_comb begin
        q_vec = '0;
        for (int k = 0; k < NB; k++) q_vec[k*DW +: DW] = qword(cyc, k);
    end

    nbank_mem_cof_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB),
                                  .LEN_WIDTH(LW)) bus1 ();
    nbank_mem_cof_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB),
                                  .LEN_WIDTH(LW)) bus3 ();

    assign bus1.q           = q_vec;
    assign bus3.q           = q_vec;
    assign bus3.ext_sel     = bus1.ext_sel;
    assign bus3.ext_addr    = bus1.ext_addr;
    assign bus3.ext_ren     = bus1.ext_ren;
    assign bus3.sys_addr    = bus1.sys_addr;
    assign bus3.sys_cen_sel = bus1.sys_cen_sel;
    assign bus3.sys_wen_in  = bus1.sys_wen_in;
    assign bus3.burst_start = bus1.burst_start;
    assign bus3.burst_base  = bus1.burst_base;
    assign bus3.burst_len   = bus1.burst_len;

    nbank_mem_cof_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB), .RD_LAT(1),
                               .LEN_WIDTH(LW)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    nbank_mem_cof_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB), .RD_LAT(3),
                               .LEN_WIDTH(LW)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the latency-1 controller.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.rdata_valid === 1'b1) begin
            if (rq1.size() == 0) chk("lat1 unexpected valid", 32'(bus1.rdata_valid), 0);
            else begin
                e = rq1.pop_front();
                chk("lat1 valid cycle", cyc, e.cyc);
                chk("lat1 rdata", bus1.rdata, qword(cyc, e.bank));
            end
        end else if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
            chk("lat1 missing valid", 32'(bus1.rdata_valid), 1);
            void'(rq1.pop_front());
        end
        if (bus1.burst_done === 1'b1) begin
            if (dq1.size() == 0) chk("lat1 unexpected done", 32'(bus1.burst_done), 0);
            else chk("lat1 done cycle", cyc, dq1.pop_front());
        end else if (dq1.size() > 0 && dq1[0] == cyc) begin
            chk("lat1 missing done", 32'(bus1.burst_done), 1);
            void'(dq1.pop_front());
        end
    end

    // Monitor for the latency-3 controller.
    always @(negedge clk) begin
        exp_t e;
        if (bus3.rdata_valid === 1'b1) begin
            if (rq3.size() == 0) chk("lat3 unexpected valid", 32'(bus3.rdata_valid), 0);
            else begin
                e = rq3.pop_front();
                chk("lat3 valid cycle", cyc, e.cyc);
                chk("lat3 rdata", bus3.rdata, qword(cyc, e.bank));
            end
        end else if (rq3.size() > 0 && rq3[0].cyc == cyc) begin
            chk("lat3 missing valid", 32'(bus3.rdata_valid), 1);
            void'(rq3.pop_front());
        end
        if (bus3.burst_done === 1'b1) begin
            if (dq3.size() == 0) chk("lat3 unexpected done", 32'(bus3.burst_done), 0);
            else chk("lat3 done cycle", cyc, dq3.pop_front());
        end else if (dq3.size() > 0 && dq3[0] == cyc) begin
            chk("lat3 missing done", 32'(bus3.burst_done), 1);
            void'(dq3.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.ext_sel     = 1'b0;
        bus1.ext_addr    = '0;
        bus1.ext_ren     = 1'b0;
        bus1.sys_addr    = '0;
        bus1.sys_cen_sel = 1'b0;
        bus1.sys_wen_in  = 1'b1;
        bus1.burst_start = 1'b0;
        bus1.burst_base  = '0;
        bus1.burst_len   = '0;
    endtask

    task automatic push_read(input int unsigned bank);
        rq1.push_back('{cyc + 1, bank});
        rq3.push_back('{cyc + 3, bank});
    endtask

    // Called in the cycle burst_start is driven; RUN occupies the following len cycles.
    task automatic expect_burst(input logic [AW-1:0] base, input int unsigned len);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            rq1.push_back('{cyc + 1 + i + 1, a[AW-1 -: BB]});
            rq3.push_back('{cyc + 1 + i + 3, a[AW-1 -: BB]});
        end
        if (len == 0) begin
            dq1.push_back(cyc + 1);
            dq3.push_back(cyc + 1);
        end else begin
            dq1.push_back(cyc + len + 1);
            dq3.push_back(cyc + len + 3);
        end
    endtask

    logic [3:0]  cen_tab [4];
    logic [11:0] ba_tab  [4];

    initial begin
        cen_tab = '{4'b0001, 4'b0001, 4'b0010, 4'b0010};
        ba_tab  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        rst_n = 1'b0;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst busy1", 32'(bus1.burst_busy), 0);
        chk("rst busy3", 32'(bus3.burst_busy), 0);
        chk("rst done1", 32'(bus1.burst_done), 0);
        chk("rst valid1", 32'(bus1.rdata_valid), 0);
        chk("rst valid3", 32'(bus3.rdata_valid), 0);
        chk("rst rdata1 bank0", bus1.rdata, qword(cyc, 0));
        chk("rst cen1", 32'(bus1.cen), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single ext read into bank 2
        tick();
        bus1.ext_sel = 1'b1; bus1.ext_ren = 1'b1; bus1.sys_cen_sel = 1'b1;
        bus1.ext_addr = 14'h2005;
        push_read(2);
        #3;
        chk("ext cen 0x2005", 32'(bus1.cen), 32'b0100);
        chk("ext bank_addr 0x2005", 32'(bus1.bank_addr), 32'h005);
        chk("ext wen_out", 32'(bus1.sys_wen_out), 1);
        tick();
        idle();

        // Back-to-back ext reads, bank 0 then bank 3
        tick();
        bus1.ext_sel = 1'b1; bus1.ext_ren = 1'b1; bus1.sys_cen_sel = 1'b1;
        bus1.ext_addr = 14'h0001;
        push_read(0);
        #3;
        chk("ext cen 0x0001", 32'(bus1.cen), 32'b0001);
        chk("ext bank_addr 0x0001", 32'(bus1.bank_addr), 32'h001);
        tick();
        bus1.ext_addr = 14'h3FFF;
        push_read(3);
        #3;
        chk("ext cen 0x3FFF", 32'(bus1.cen), 32'b1000);
        chk("ext bank_addr 0x3FFF", 32'(bus1.bank_addr), 32'hFFF);
        // Request without sys_cen_sel is neither enabled nor returned
        tick();
        bus1.sys_cen_sel = 1'b0;
        bus1.ext_addr = 14'h2005;
        #3;
        chk("ext no cen_sel cen", 32'(bus1.cen), 0);
        tick();
        idle();
        repeat (4) tick();

        // Host path: disabled banks, write enable pass-through, then bank 1
        bus1.sys_wen_in = 1'b0;
        bus1.sys_addr = 14'h1000;
        #3;
        chk("sys disabled cen", 32'(bus1.cen), 0);
        chk("sys wen_out low", 32'(bus1.sys_wen_out), 0);
        tick();
        bus1.sys_cen_sel = 1'b1;
        #3;
        chk("sys cen 0x1000", 32'(bus1.cen), 32'b0010);
        chk("sys bank_addr 0x1000", 32'(bus1.bank_addr), 0);
        chk("sys wen_out held", 32'(bus1.sys_wen_out), 0);
        tick();
        idle();
        tick();

        // Burst across the bank0/bank1 boundary
        bus1.burst_start = 1'b1; bus1.burst_base = 14'h0FFE; bus1.burst_len = 14'd4;
        expect_burst(14'h0FFE, 4);
        #3;
        chk("burst start busy1", 32'(bus1.burst_busy), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus1.burst_start = 1'b0;
            bus1.sys_wen_in = 1'b0;
            #3;
            chk("burst cen", 32'(bus1.cen), (k <= 4) ? 32'(cen_tab[k-1]) : 0);
            if (k <= 4) chk("burst bank_addr", 32'(bus1.bank_addr), 32'(ba_tab[k-1]));
            chk("burst wen_out", 32'(bus1.sys_wen_out), (k <= 4) ? 1 : 0);
            chk("burst busy1", 32'(bus1.burst_busy), (k <= 5) ? 1 : 0);
            chk("burst busy3", 32'(bus3.burst_busy), (k <= 7) ? 1 : 0);
        end
        tick();
        idle();

        // Wrapping burst; a second start while running is ignored
        tick();
        bus1.burst_start = 1'b1; bus1.burst_base = 14'h3FFF; bus1.burst_len = 14'd2;
        expect_burst(14'h3FFF, 2);
        tick();
        bus1.burst_base = 14'h2000; bus1.burst_len = 14'd5;
        #3;
        chk("wrap cen 0x3FFF", 32'(bus1.cen), 32'b1000);
        chk("wrap bank_addr 0x3FFF", 32'(bus1.bank_addr), 32'hFFF);
        tick();
        bus1.burst_start = 1'b0;
        #3;
        chk("wrap cen 0x0000", 32'(bus1.cen), 32'b0001);
        chk("wrap bank_addr 0x0000", 32'(bus1.bank_addr), 0);
        repeat (5) tick();
        #3;
        chk("wrap end busy1", 32'(bus1.burst_busy), 0);
        chk("wrap end busy3", 32'(bus3.burst_busy), 0);
        idle();

        // Zero-length burst
        tick();
        bus1.burst_start = 1'b1; bus1.burst_base = 14'h2000; bus1.burst_len = '0;
        expect_burst(14'h2000, 0);
        tick();
        bus1.burst_start = 1'b0;
        #3;
        chk("len0 busy1", 32'(bus1.burst_busy), 1);
        chk("len0 busy3", 32'(bus3.burst_busy), 1);
        chk("len0 cen", 32'(bus1.cen), 0);
        tick();
        #3;
        chk("len0 after busy1", 32'(bus1.burst_busy), 0);
        chk("len0 after busy3", 32'(bus3.burst_busy), 0);

        // Reset in the middle of a burst abandons it without a done pulse
        tick();
        bus1.burst_start = 1'b1; bus1.burst_base = 14'h1234; bus1.burst_len = 14'd6;
        expect_burst(14'h1234, 6);
        tick();
        bus1.burst_start = 1'b0;
        tick();
        tick();
        #1;
        chk("pre-rst cen", 32'(bus1.cen), 32'b0010);
        rst_n = 1'b0;
        rq1.delete(); rq3.delete(); dq1.delete(); dq3.delete();
        #1;
        chk("mid-rst busy1", 32'(bus1.burst_busy), 0);
        chk("mid-rst busy3", 32'(bus3.burst_busy), 0);
        chk("mid-rst cen", 32'(bus1.cen), 0);
        chk("mid-rst valid1", 32'(bus1.rdata_valid), 0);
        chk("mid-rst valid3", 32'(bus3.rdata_valid), 0);
        chk("mid-rst done3", 32'(bus3.burst_done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus1.burst_start = 1'b1; bus1.burst_base = 14'h2FFF; bus1.burst_len = 14'd3;
        expect_burst(14'h2FFF, 3);
        tick();
        bus1.burst_start = 1'b0;
        #3;
        chk("post-rst cen", 32'(bus1.cen), 32'b0100);
        chk("post-rst busy1", 32'(bus1.burst_busy), 1);
        repeat (9) tick();

        chk("lat1 reads retired", rq1.size(), 0);
        chk("lat3 reads retired", rq3.size(), 0);
        chk("lat1 dones retired", dq1.size(), 0);
        chk("lat3 dones retired", dq3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
